// File: rtl/ddr_local_if_pkg.sv
// ddr_local_if_pkg: state encoding and address helpers shared by the DDR local-interface stage
package ddr_local_if_pkg;

  localparam int DEF_MAX_BW = 3;

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_REQ  = 3'd3,
    S_READ_DATA = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Clamp the requested log2 burst length to what the controller supports.
  function automatic logic [3:0] eff_bw(input logic [3:0] bw, input int max_bw);
    return (int'(bw) > max_bw) ? 4'(max_bw) : bw;
  endfunction

  // Word address of a byte address with the low bw bits cleared, so a burst never wraps.
  function automatic logic [29:0] aligned_base(input logic [31:0] adr, input logic [3:0] bw);
    return adr[31:2] & ~((30'd1 << bw) - 30'd1);
  endfunction

endpackage

// File: rtl/ddr_local_if_if.sv
// ddr_local_if_if: arbiter-side access bus and Altera DDR controller local bus
interface ddr_acc_if;
  logic        acc_i;
  logic        we_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [3:0]  buf_width_i;
  logic        ack_o;
  logic [31:0] dat_o;
  logic [31:0] adr_o;

  modport master (
    output acc_i, we_i, adr_i, dat_i, sel_i, buf_width_i,
    input  ack_o, dat_o, adr_o
  );

  modport slave (
    input  acc_i, we_i, adr_i, dat_i, sel_i, buf_width_i,
    output ack_o, dat_o, adr_o
  );
endinterface

interface ddr_lcl_if #(
  parameter int ADR_WIDTH = 24,
  parameter int MAX_BW    = 3
);
  logic                 local_init_done;
  logic                 local_ready;
  logic [ADR_WIDTH-1:0] local_address;
  logic                 local_read_req;
  logic                 local_write_req;
  logic                 local_burstbegin;
  logic [MAX_BW:0]      local_size;
  logic [3:0]           local_be;
  logic [31:0]          local_wdata;
  logic [31:0]          local_rdata;
  logic                 local_rdata_valid;

  modport master (
    input  local_init_done, local_ready, local_rdata, local_rdata_valid,
    output local_address, local_read_req, local_write_req, local_burstbegin,
           local_size, local_be, local_wdata
  );

  modport slave (
    output local_init_done, local_ready, local_rdata, local_rdata_valid,
    input  local_address, local_read_req, local_write_req, local_burstbegin,
           local_size, local_be, local_wdata
  );
endinterface

// File: rtl/ddr_local_if.sv
// ddr_local_if: turns one granted arbiter access into an Altera DDR local-interface transaction
module ddr_local_if
  import ddr_local_if_pkg::*;
#(
  parameter int ADR_WIDTH = 24,
  parameter int MAX_BW    = DEF_MAX_BW
) (
  input  logic       sdram_clk,
  input  logic       sdram_rst_n,
  ddr_acc_if.slave   acc,
  ddr_lcl_if.master  lcl,
  output logic       sdram_idle_o
);

  state_t               state, state_nx;
  logic [MAX_BW:0]      beat;
  logic                 last_beat;
  logic [3:0]           bw;
  logic [ADR_WIDTH-1:0] base;
  logic [29:0]          word;
  logic                 take;

  assign bw        = eff_bw(acc.buf_width_i, MAX_BW);
  assign base      = ADR_WIDTH'(acc.we_i ? acc.adr_i[31:2] : aligned_base(acc.adr_i, bw));
  assign take      = state == S_IDLE && acc.acc_i;
  assign last_beat = beat == lcl.local_size - (MAX_BW+1)'(1);
  assign word      = 30'(lcl.local_address) + 30'(beat);

  assign sdram_idle_o         = state == S_INIT || state == S_IDLE;
  assign lcl.local_write_req  = state == S_WRITE;
  assign lcl.local_read_req   = state == S_READ_REQ;
  assign lcl.local_burstbegin = state == S_WRITE || state == S_READ_REQ;

  // State register; reset drops any burst in flight.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) state <= S_INIT;
    else state <= state_nx;
  end

  // Next state; DONE never samples acc_i so a held request cannot restart early.
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:      state_nx = lcl.local_init_done ? S_IDLE : S_INIT;
      S_IDLE:      state_nx = !acc.acc_i ? S_IDLE : acc.we_i ? S_WRITE : S_READ_REQ;
      S_WRITE:     state_nx = lcl.local_ready ? S_DONE : S_WRITE;
      S_READ_REQ:  state_nx = lcl.local_ready ? S_READ_DATA : S_READ_REQ;
      S_READ_DATA: state_nx = lcl.local_rdata_valid && last_beat ? S_DONE : S_READ_DATA;
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_INIT;
    endcase
  end

  // Request fields latched once per access, beat counter and read-data return path.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      lcl.local_address <= '0;
      lcl.local_size    <= '0;
      lcl.local_be      <= '0;
      lcl.local_wdata   <= '0;
      beat              <= '0;
      acc.ack_o         <= 1'b0;
      acc.dat_o         <= '0;
      acc.adr_o         <= '0;
    end else begin
      acc.ack_o <= (state == S_WRITE && lcl.local_ready) ||
                   (state == S_READ_DATA && lcl.local_rdata_valid);
      if (take) begin
        lcl.local_address <= base;
        lcl.local_size    <= acc.we_i ? (MAX_BW+1)'(1) : (MAX_BW+1)'(1) << bw;
        lcl.local_be      <= acc.sel_i;
        lcl.local_wdata   <= acc.dat_i;
      end
      if (state == S_READ_REQ) beat <= '0;
      if (state == S_READ_DATA && lcl.local_rdata_valid) begin
        acc.dat_o <= lcl.local_rdata;
        acc.adr_o <= {word, 2'b00};
        beat      <= beat + (MAX_BW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_ddr_local_if.sv
// tb_ddr_local_if: randomized scoreboard bench with a behavioural DDR controller model
module tb_ddr_local_if;

  localparam int AW  = 24;
  localparam int MBW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle;
  always #5 clk = ~clk;

  ddr_acc_if acc();
  ddr_lcl_if #(.ADR_WIDTH(AW), .MAX_BW(MBW)) lcl();

  ddr_local_if #(.ADR_WIDTH(AW), .MAX_BW(MBW)) dut (
    .sdram_clk(clk),
    .sdram_rst_n(rst_n),
    .acc(acc),
    .lcl(lcl),
    .sdram_idle_o(idle)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] size;
    logic [31:0] be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
  } ack_t;

  req_t req_q[$];
  ack_t ack_q[$];
  int   time_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acks = 0;
  int beats_left = 0;
  logic [31:0] beat_w = 0;
  int force_stall = 0;
  int stall_cnt = 0;
  bit drop_beats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem(input logic [31:0] w);
    return (w * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
  endtask

  // Controller model: checks each presented request, answers with ready and read beats.
  always @(negedge clk) begin
    req_t r;
    bit rdy;
    lcl.local_rdata_valid = 1'b0;
    if (beats_left > 0 && $urandom_range(3) != 0) begin
      lcl.local_rdata_valid = 1'b1;
      lcl.local_rdata = mem(beat_w);
      beat_w++;
      beats_left--;
      if (!drop_beats) time_q.push_back(cyc + 1);
    end
    if (lcl.local_read_req || lcl.local_write_req) begin
      if (req_q.size() == 0) fail("req_unexpected");
      else begin
        r = req_q[0];
        check("req_write", lcl.local_write_req, r.we);
        check("req_read", lcl.local_read_req, !r.we);
        check("req_burstbegin", lcl.local_burstbegin, 1);
        check("req_address", lcl.local_address, r.addr);
        check("req_size", lcl.local_size, r.size);
        if (r.we) begin
          check("req_be", lcl.local_be, r.be);
          check("req_wdata", lcl.local_wdata, r.wdata);
        end
      end
      rdy = stall_cnt < force_stall ? 1'b0 : force_stall > 0 ? 1'b1 : 1'($urandom_range(1));
      if (!rdy) stall_cnt++;
      lcl.local_ready = rdy;
      if (rdy) begin
        stall_cnt = 0;
        force_stall = 0;
        if (lcl.local_read_req) begin
          beats_left = int'(lcl.local_size);
          beat_w = 32'(lcl.local_address);
        end else time_q.push_back(cyc + 1);
        if (req_q.size() > 0) void'(req_q.pop_front());
      end
    end else begin
      check("burstbegin_idle", lcl.local_burstbegin, 0);
      lcl.local_ready = 1'($urandom_range(1));
    end
  end

  // Monitor: every ack must match the next expected response in value and in cycle.
  always @(negedge clk) begin
    ack_t a;
    int t;
    if (acc.ack_o) begin
      if (ack_q.size() == 0 || time_q.size() == 0) fail("ack_unexpected");
      else begin
        a = ack_q.pop_front();
        t = time_q.pop_front();
        check("ack_cycle", cyc, t);
        check("ack_not_idle", idle, 0);
        if (!a.we) begin
          check("ack_adr", acc.adr_o, a.adr);
          check("ack_dat", acc.dat_o, a.dat);
        end
      end
      acks++;
    end
  end

  task automatic start_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [3:0] bw, input int stall);
    req_t r;
    ack_t a;
    int eb;
    logic [31:0] base;
    eb = bw > MBW ? MBW : int'(bw);
    base = we ? (adr & 32'h03FF_FFFC) : (adr & 32'h03FF_FFFF & ~((32'd4 << eb) - 1));
    r.we = we;
    r.addr = base >> 2;
    r.size = we ? 1 : (1 << eb);
    r.be = 32'(sel);
    r.wdata = dat;
    req_q.push_back(r);
    if (we) begin
      a = '{1'b1, 32'h0, 32'h0};
      ack_q.push_back(a);
    end else begin
      for (int i = 0; i < r.size; i++) begin
        a.we = 1'b0;
        a.adr = base + 32'(4 * i);
        a.dat = mem(a.adr >> 2);
        ack_q.push_back(a);
      end
    end
    force_stall = stall;
    acc.acc_i = 1'b1;
    acc.we_i = we;
    acc.adr_i = adr;
    acc.dat_i = dat;
    acc.sel_i = sel;
    acc.buf_width_i = bw;
  endtask

  task automatic finish_txn(input bit drop);
    int k;
    for (k = 0; k < 400 && (ack_q.size() != 0 || req_q.size() != 0); k++) begin
      @(posedge clk);
      #2;
    end
    if (k == 400) begin
      fail("txn_timeout");
      ack_q.delete();
      req_q.delete();
      time_q.delete();
    end
    check("idle_after_txn", idle, 1);
    if (drop) begin
      acc.acc_i = 1'b0;
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #2;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acks;
    int k;
    acc.acc_i = 0;
    acc.we_i = 0;
    acc.adr_i = 0;
    acc.dat_i = 0;
    acc.sel_i = 0;
    acc.buf_width_i = 0;
    lcl.local_init_done = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ack", acc.ack_o, 0);
    check("rst_dat", acc.dat_o, 0);
    check("rst_adr", acc.adr_o, 0);
    check("rst_address", lcl.local_address, 0);
    check("rst_size", lcl.local_size, 0);
    check("rst_be", lcl.local_be, 0);
    check("rst_wdata", lcl.local_wdata, 0);
    check("rst_reqs", {lcl.local_read_req, lcl.local_write_req, lcl.local_burstbegin}, 0);
    check("rst_idle", idle, 1);
    rst_n = 1;

    // Read 0x104 requested before calibration completes.
    start_txn(0, 32'h0000_0104, 0, 0, 3, 0);
    repeat (20) begin
      @(posedge clk);
      #2;
      check("init_no_req", lcl.local_read_req | lcl.local_write_req, 0);
      check("init_idle", idle, 1);
    end
    lcl.local_init_done = 1;
    @(posedge clk);
    #2;
    check("init_req_early", lcl.local_read_req, 0);
    @(posedge clk);
    #2;
    check("init_req_2cyc", lcl.local_read_req, 1);
    finish_txn(1);

    // Stalled write.
    start_txn(1, 32'h0000_1234, 32'hDEAD_BEEF, 4'b0110, 0, 3);
    finish_txn(1);

    // Oversized burst width clamps to eight beats.
    start_txn(0, $urandom, $urandom, 4'hF, 5, 0);
    finish_txn(1);

    // Request held high across DONE straight into the next write.
    start_txn(1, $urandom, $urandom, 4'b1001, 0, 1);
    finish_txn(0);
    start_txn(1, $urandom, $urandom, 4'b0011, 0, 0);
    finish_txn(1);

    for (int n = 0; n < 40; n++) begin
      start_txn(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)),
                4'($urandom_range(7)), $urandom_range(2));
      finish_txn(1'($urandom_range(1)));
    end

    // Reset in the middle of an eight-beat read.
    base_acks = acks;
    start_txn(0, 32'h0000_2000, 0, 0, 3, 0);
    for (k = 0; k < 400 && acks < base_acks + 3; k++) begin
      @(posedge clk);
      #2;
    end
    if (k == 400) fail("reset_wait_timeout");
    rst_n = 0;
    drop_beats = 1;
    acc.acc_i = 0;
    ack_q.delete();
    time_q.delete();
    req_q.delete();
    #1;
    check("midrst_ack", acc.ack_o, 0);
    check("midrst_dat", acc.dat_o, 0);
    check("midrst_adr", acc.adr_o, 0);
    check("midrst_address", lcl.local_address, 0);
    check("midrst_size", lcl.local_size, 0);
    check("midrst_reqs", {lcl.local_read_req, lcl.local_write_req}, 0);
    check("midrst_idle", idle, 1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    for (k = 0; k < 100 && beats_left > 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (k == 100) fail("drain_timeout");
    repeat (2) @(posedge clk);
    #2;
    check("postrst_idle", idle, 1);
    check("postrst_adr", acc.adr_o, 0);
    check("postrst_dat", acc.dat_o, 0);
    drop_beats = 0;

    start_txn(0, $urandom, 0, 0, 2, 0);
    finish_txn(1);
    start_txn(1, $urandom, $urandom, 4'b1111, 0, 0);
    finish_txn(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
